parity_frame_rx: RTL and testbench
==================================

Name: parity_frame_rx

Overview:
- Serial frame receiver that sits directly upstream of the parity checker.
- Deserializes an asynchronous serial line carrying frames of 1 start bit, 8 data bits (LSB first), 1 parity bit and 1 stop bit.
- Presents the data byte and the received parity bit in parallel to the parity checker's data_in / parity_bit inputs.
- Parity convention is even: the transmitter sends the XOR-reduction of the data byte. This block does not judge parity; it transports the bit.

Parameters:
- CLKS_PER_BIT, 16, clock cycles per serial bit period; legal minimum 4; must be even.
- DATA_W, 8, data bits per frame; fixed at 8 for this revision.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- rx_serial  input  1  raw serial line, idle high, asynchronous to clk.
- data_out  output  8  last good data byte; feeds the parity checker's data_in.
- parity_out  output  1  parity bit of the last good frame; feeds the parity checker's parity_bit.
- frame_valid  output  1  one-cycle pulse; data_out/parity_out updated this cycle.
- frame_error  output  1  one-cycle pulse; stop bit sampled low.
- busy  output  1  high while a frame is in progress (any state other than IDLE / WAIT_HIGH).

Behaviour:
- Reset and synchronization
  - Reset (async assert, sync deassert via clk): data_out=0, parity_out=0, frame_valid=0, frame_error=0, busy=0, state=IDLE, all counters and the shift register 0.
  - rx_serial passes through a 2-flop synchronizer, which resets to 1. All logic uses the synchronized value rxs, so there is 2 cycles of pin-to-rxs latency.
- States: IDLE, START, DATA, PARITY, STOP, WAIT_HIGH.
  - IDLE: rxs==0 → START; bit counter=0. Call this cycle T0.
  - Sample points: bit k (start k=0, data k=1..8, parity k=9, stop k=10) is sampled at T0 + CLKS_PER_BIT/2 + k*CLKS_PER_BIT.
  - START: sampled value 1 → false start, return to IDLE with no output pulses. Sampled value 0 → DATA.
  - DATA: each sample shifts in LSB-first; after the 8th sample → PARITY.
  - PARITY: sample is latched into the shadow parity bit → STOP.
  - STOP, sample 1: data_out and parity_out load from the shadow registers; frame_valid=1 in the next cycle → IDLE.
  - STOP, sample 0: frame_error=1 in the next cycle; data_out/parity_out keep their previous values → WAIT_HIGH.
  - WAIT_HIGH: stays until rxs==1 for one cycle, then → IDLE. A held-low break line never triggers a new start.
- Outputs and timing
  - frame_valid and frame_error are mutually exclusive and never high for more than one cycle.
  - Back-to-back frames: a start edge arriving at the stop-bit end is accepted. IDLE is entered before the next start bit's midpoint, so zero idle gap is supported.
  - data_out/parity_out are registered and stable between frame_valid pulses, so the downstream checker sees a steady pair.
  - Reset mid-frame aborts the frame immediately, with no pulse.
- Counter widths
  - Baud counter width = $clog2(CLKS_PER_BIT); it wraps to 0 at each sample point.
  - Bit counter is 4 bits; no overflow is possible.

Optional Feature:
- Macro: RX_GLITCH_FILTER_EN.
- Defined: each sample is the 2-of-3 majority of rxs at sample point −1, 0 and +1 cycles. The decision is made at +1, so frame_valid/frame_error occur 1 cycle later than the unfiltered timing.
- Undefined: single sample at the sample point.
- Port list is identical in both builds.

Decomposition:
- Package parity_rx_pkg contains:
  - state enum (IDLE, START, DATA, PARITY, STOP, WAIT_HIGH);
  - DATA_W;
  - bit index constants START_IDX=0, PARITY_IDX=9, STOP_IDX=10.
- One sub-module: rx_sync, a 2-flop synchronizer with a reset value parameter (1 here).

Test Plan:
1. Frame 0xAA, parity 0, stop 1 (CLKS_PER_BIT=16) → frame_valid pulse at T0+8+160+1 (cycle after the stop sample), data_out=0xAA, parity_out=0, frame_error=0; checker error=0.
2. Frame 0xAB, parity 0 (wrong), stop 1 → data_out=0xAB, parity_out=0, frame_valid pulse; connected checker error=1.
3. Frame 0x3C with stop bit 0 → frame_error one-cycle pulse, no frame_valid, data_out retains 0xAB; line held low 50 cycles → no new start until the line is high again.
4. rx_serial low for 4 cycles, then high → busy rises then returns to 0; no pulses; data_out unchanged.
5. Assert rst_n=0 during data bit 4 of a frame → all outputs 0 immediately. Then send 0x55 with parity 0 → received correctly.
6. Back-to-back 0x55/p0 then 0x0F/p0 with zero gap → two frame_valid pulses exactly 176 cycles apart. With RX_GLITCH_FILTER_EN, a one-cycle high glitch at the mid-point of a 0 data bit leaves the byte correct.

Source files
------------

// File: rtl/parity_rx_pkg.sv
// parity_rx_pkg: shared state encoding and frame constants for parity_frame_rx
package parity_rx_pkg;
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, WAIT_HIGH} state_t;
    localparam int DATA_W = 8;
    localparam logic [3:0] START_IDX  = 4'd0;
    localparam logic [3:0] PARITY_IDX = 4'd9;
    localparam logic [3:0] STOP_IDX   = 4'd10;
endpackage

// File: rtl/rx_sync.sv
// rx_sync: two-flop synchronizer with a configurable reset value
module rx_sync #(
    parameter logic RST_VAL = 1'b1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);
    logic m;
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) {q, m} <= {RST_VAL, RST_VAL};
        else        {q, m} <= {m, d};
endmodule

// File: rtl/parity_frame_rx.sv
// parity_frame_rx: 8-bit data + parity serial frame receiver; RX_GLITCH_FILTER_EN adds 2-of-3 majority sampling
module parity_frame_rx
    import parity_rx_pkg::*;
#(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              rx_serial,
    output logic [DATA_W-1:0] data_out,
    output logic              parity_out,
    output logic              frame_valid,
    output logic              frame_error,
    output logic              busy
);
    localparam int CW = $clog2(CLKS_PER_BIT);
    state_t state, state_n;
    logic rxs, smp, tick, valid_n, err_n, par;
    logic [CW-1:0] cnt;
    logic [3:0] bit_idx;
    logic [DATA_W-1:0] sh;
    rx_sync #(.RST_VAL(1'b1)) u_sync (.clk(clk), .rst_n(rst_n), .d(rx_serial), .q(rxs));
`ifdef RX_GLITCH_FILTER_EN
    localparam int OFF = 1;
    logic [1:0] hist;
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) hist <= 2'b11;
        else        hist <= {hist[0], rxs};
    // decision one cycle after the sample point: rxs=+1, hist[0]=0, hist[1]=-1
    assign smp = (rxs & hist[0]) | (rxs & hist[1]) | (hist[0] & hist[1]);
`else
    localparam int OFF = 0;
    assign smp = rxs;
`endif
    localparam logic [CW-1:0] FIRST = CW'(CLKS_PER_BIT / 2 - 1 + OFF);
    localparam logic [CW-1:0] LAST  = CW'(CLKS_PER_BIT - 1);
    assign tick = (state == START) ? (cnt == FIRST) : (cnt == LAST);
    assign busy = !(state == IDLE || state == WAIT_HIGH);
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) state <= IDLE;
        else        state <= state_n;
    always_comb begin
        state_n = state;
        valid_n = 1'b0;
        err_n   = 1'b0;
        case (state)
            IDLE:      state_n = rxs ? IDLE : START;
            START:     if (tick) state_n = smp ? IDLE : DATA;
            DATA:      if (tick && bit_idx == PARITY_IDX - 4'd1) state_n = PARITY;
            PARITY:    if (tick) state_n = STOP;
            STOP: if (tick && bit_idx == STOP_IDX) begin
                state_n = smp ? IDLE : WAIT_HIGH;
                valid_n = smp;
                err_n   = !smp;
            end
            WAIT_HIGH: state_n = rxs ? IDLE : WAIT_HIGH;
            default:   state_n = IDLE;
        endcase
    end
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            cnt         <= '0;
            bit_idx     <= '0;
            sh          <= '0;
            par         <= 1'b0;
            data_out    <= '0;
            parity_out  <= 1'b0;
            frame_valid <= 1'b0;
            frame_error <= 1'b0;
        end else begin
            cnt         <= (!busy || tick) ? '0 : cnt + 1'b1;
            bit_idx     <= (state == IDLE) ? START_IDX : tick ? bit_idx + 4'd1 : bit_idx;
            sh          <= (state == DATA && tick) ? {smp, sh[DATA_W-1:1]} : sh;
            par         <= (state == PARITY && tick) ? smp : par;
            data_out    <= valid_n ? sh : data_out;
            parity_out  <= valid_n ? par : parity_out;
            frame_valid <= valid_n;
            frame_error <= err_n;
        end
endmodule

// File: tb/tb_parity_frame_rx.sv
// tb_parity_frame_rx: randomized frame stimulus checked against a frame-level reference model
module tb_parity_frame_rx;
    localparam int C = 16;
    localparam int H = C / 2;
`ifdef RX_GLITCH_FILTER_EN
    localparam int OFF = 1;
`else
    localparam int OFF = 0;
`endif
    // pin edge -> 2 sync flops -> IDLE detect, then mid-start + 10 bit periods, then registered pulse
    localparam int LAT = 3 + H + 10 * C + OFF;

    logic clk = 1'b0, rst_n = 1'b0, rx_serial = 1'b1;
    logic [7:0] data_out;
    logic parity_out, frame_valid, frame_error, busy;
    int cyc = 0, n_vec = 0, n_err = 0;
    typedef struct {int cyc; logic [7:0] d; logic p;} ev_t;
    ev_t vq[$];
    int eq[$];
    logic prev_v = 1'b0, prev_e = 1'b0;
    logic [7:0] last_d = 8'h00;
    logic last_p = 1'b0;

    parity_frame_rx #(.CLKS_PER_BIT(C)) dut (
        .clk(clk), .rst_n(rst_n), .rx_serial(rx_serial), .data_out(data_out),
        .parity_out(parity_out), .frame_valid(frame_valid), .frame_error(frame_error), .busy(busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    always @(negedge clk) begin
        if (frame_valid) vq.push_back('{cyc, data_out, parity_out});
        if (frame_error) eq.push_back(cyc);
        if (frame_valid || frame_error) begin
            check("excl", 32'(frame_valid & frame_error), 32'd0);
            check("width", 32'((frame_valid & prev_v) | (frame_error & prev_e)), 32'd0);
        end
        prev_v = frame_valid;
        prev_e = frame_error;
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send(input logic [7:0] d, input logic p, input logic s, input int nb,
                        input int gl, output int t0);
        logic [10:0] bits;
        bits = {s, p, d, 1'b0};
        t0 = cyc;
        for (int k = 0; k < nb; k++) begin
            rx_serial = bits[k];
            if (k == gl) begin
                tick(H);
                rx_serial = ~bits[k];
                tick(1);
                rx_serial = bits[k];
                tick(C - H - 1);
            end else tick(C);
        end
    endtask

    task automatic expect_frame(input int t0, input logic [7:0] d, input logic p, input logic s,
                                output int pc);
        ev_t ev;
        int ec;
        pc = -1;
        if (s) begin
            check("n_valid", vq.size(), 32'd1);
            check("n_error", eq.size(), 32'd0);
            if (vq.size() > 0) begin
                ev = vq.pop_front();
                pc = ev.cyc;
                check("data", 32'(ev.d), 32'(d));
                check("parity", 32'(ev.p), 32'(p));
                check("valid_time", ev.cyc, t0 + LAT);
                check("checker_err", 32'(^data_out ^ parity_out), 32'((^d) != p));
            end
            last_d = d;
            last_p = p;
        end else begin
            check("n_error", eq.size(), 32'd1);
            check("n_valid", vq.size(), 32'd0);
            if (eq.size() > 0) begin
                ec = eq.pop_front();
                check("error_time", ec, t0 + LAT);
            end
            check("data_hold", 32'(data_out), 32'(last_d));
            check("parity_hold", 32'(parity_out), 32'(last_p));
        end
        vq.delete();
        eq.delete();
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_data"}, 32'(data_out), 32'd0);
        check({tag, "_par"}, 32'(parity_out), 32'd0);
        check({tag, "_valid"}, 32'(frame_valid), 32'd0);
        check({tag, "_error"}, 32'(frame_error), 32'd0);
        check({tag, "_busy"}, 32'(busy), 32'd0);
    endtask

    initial begin
        int t0, t1, c1, c2, g;
        logic [7:0] d;
        logic p, s;
        tick(3);
        check_zero("reset");
        rst_n = 1'b1;
        tick(5);

        send(8'hAA, 1'b0, 1'b1, 11, -1, t0);
        expect_frame(t0, 8'hAA, 1'b0, 1'b1, c1);
        tick(4);
        send(8'hAB, 1'b0, 1'b1, 11, -1, t0);
        expect_frame(t0, 8'hAB, 1'b0, 1'b1, c1);
        tick(4);

        send(8'h3C, 1'b0, 1'b0, 11, -1, t0);
        expect_frame(t0, 8'h3C, 1'b0, 1'b0, c1);
        tick(50);
        check("break_busy", 32'(busy), 32'd0);
        check("break_pulses", vq.size() + eq.size(), 32'd0);
        rx_serial = 1'b1;
        tick(10);
        check("break_end_busy", 32'(busy), 32'd0);

        rx_serial = 1'b0;
        tick(4);
        rx_serial = 1'b1;
        check("false_busy_hi", 32'(busy), 32'd1);
        tick(30);
        check("false_busy_lo", 32'(busy), 32'd0);
        check("false_pulses", vq.size() + eq.size(), 32'd0);
        check("false_data", 32'(data_out), 32'hAB);

        send(8'h55, 1'b0, 1'b1, 5, -1, t0);
        rx_serial = 1'b1;
        tick(H);
        rst_n = 1'b0;
        #1;
        check_zero("abort");
        tick(3);
        rst_n = 1'b1;
        tick(5);
        check("abort_pulses", vq.size() + eq.size(), 32'd0);
        last_d = 8'h00;
        last_p = 1'b0;
        send(8'h55, 1'b0, 1'b1, 11, -1, t0);
        expect_frame(t0, 8'h55, 1'b0, 1'b1, c1);
        tick(3);

        send(8'h55, 1'b0, 1'b1, 11, -1, t0);
        expect_frame(t0, 8'h55, 1'b0, 1'b1, c1);
        send(8'h0F, 1'b0, 1'b1, 11, -1, t1);
        expect_frame(t1, 8'h0F, 1'b0, 1'b1, c2);
        check("b2b_gap", c2 - c1, 32'd176);
`ifdef RX_GLITCH_FILTER_EN
        tick(2);
        send(8'h00, 1'b0, 1'b1, 11, 3, t0);
        expect_frame(t0, 8'h00, 1'b0, 1'b1, c1);
`endif

        for (int i = 0; i < 24; i++) begin
            d = 8'($urandom);
            p = ($urandom_range(0, 3) == 0) ? ~^d : ^d;
            s = ($urandom_range(0, 4) != 0);
            send(d, p, s, 11, -1, t0);
            expect_frame(t0, d, p, s, c1);
            if (!s) begin
                rx_serial = 1'b1;
                g = $urandom_range(1, 4);
            end else g = $urandom_range(0, 3);
            tick(g);
        end
        rx_serial = 1'b1;
        tick(20);
        check("tail_pulses", vq.size() + eq.size(), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
